// File: rtl/tdc_top.sv
// Tapped-delay-line TDC: start launches a pulse down the line, stop freezes the
// thermometer snapshot; the done flag is brought into the clk domain as valid.
`timescale 1ps/1ps
module tdc_top #(
    parameter int NUM_TAPS     = 32,
    parameter int TAP_DELAY_PS = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        stop,
    output logic [NUM_TAPS-1:0]         taps_raw,
    output logic [$clog2(NUM_TAPS)-1:0] time_out,
    output logic                        valid
);
    localparam int CW = $clog2(NUM_TAPS);
    localparam int SW = $clog2(NUM_TAPS + 1);

    logic                r_launch;
    logic                r_done;
    logic [1:0]          r_sync;
    logic [NUM_TAPS-1:0] r_taps;
    logic [SW-1:0]       w_cnt;
    wire  [NUM_TAPS-1:0] w_tap;

    // Launch latch: start is its clock, stop/rst force it low. A stop that is
    // still high when start rises wins, so coincident edges never launch.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge start or posedge stop or posedge rst) begin
        if (rst)       r_launch <= 1'b0;
        else if (stop) r_launch <= 1'b0;
        else           r_launch <= 1'b1;
    end

    // Behavioural delay line; a synthesized build swaps in a carry chain.
    assign #(TAP_DELAY_PS) w_tap[0] = r_launch;
    for (genvar i = 1; i < NUM_TAPS; i++) begin : g_tap
        assign #(TAP_DELAY_PS) w_tap[i] = w_tap[i-1];
    end

    always_ff @(posedge stop or posedge rst) begin
        if (rst) r_taps <= '0;
        else     r_taps <= w_tap;
    end

    // Done: set by the stop capture, cleared by the next start.
    always_ff @(posedge stop or posedge start or posedge rst) begin
        if (rst)       r_done <= 1'b0;
        else if (stop) r_done <= 1'b1;
        else           r_done <= 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= 2'b00;
        else     r_sync <= {r_sync[0], r_done};
    end

    // Population count rather than priority encode, so a bubble costs one tap.
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            w_cnt = w_cnt + SW'(r_taps[i]);
        end
    end

    assign time_out = (w_cnt >= SW'(NUM_TAPS)) ? CW'(NUM_TAPS - 1) : w_cnt[CW-1:0];
    assign taps_raw = r_taps;
    assign valid    = r_sync[1];
endmodule

// File: tb/tb_tdc_top.sv
// Self-checking bench for tdc_top: directed corner cases plus randomized
// intervals checked against an arithmetic floor(interval/tap) model.
`timescale 1ps/1ps
module tb_tdc_top;
    localparam int N  = 32;
    localparam int TD = 10;

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         start = 1'b0;
    logic         stop  = 1'b0;
    logic [N-1:0] taps_raw;
    logic [4:0]   time_out;
    logic         valid;

    int n_cmp = 0;
    int n_bad = 0;

    tdc_top #(.NUM_TAPS(N), .TAP_DELAY_PS(TD)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .taps_raw (taps_raw),
        .time_out (time_out),
        .valid    (valid)
    );

    always #500 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: taps reached = floor(interval / tap delay), capped at the line length.
    function automatic int ref_count(input int d);
        int n;
        n = d / TD;
        if (n > N) n = N;
        return n;
    endfunction

    function automatic logic [N-1:0] ref_taps(input int d);
        logic [N:0] v;
        v = ({{N{1'b0}}, 1'b1} << ref_count(d)) - 1'b1;
        return v[N-1:0];
    endfunction

    function automatic logic [4:0] ref_time(input int d);
        int n;
        n = ref_count(d);
        return (n >= N) ? 5'(N - 1) : 5'(n);
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        #1 start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        #1 stop = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (valid !== 1'b1 && n < 3) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 64'(valid), 64'd1);
    endtask

    // Stop lands d ps after the first start; s>0 adds a redundant start at offset s.
    task automatic measure(input string tag, input int d, input int s);
        #400;
        pulse_start();
        if (s > 0) begin
            #(s - 1);
            pulse_start();
            #(d - s - 1);
        end else begin
            #(d - 1);
        end
        pulse_stop();
        #50;
        check({tag, "_taps"}, 64'(taps_raw), 64'(ref_taps(d)));
        check({tag, "_time"}, 64'(time_out), 64'(ref_time(d)));
        wait_valid({tag, "_valid"});
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, limit 10000000 ps");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, s;
        rst = 1'b1;
        #1;
        check("reset_taps", 64'(taps_raw), 64'd0);
        check("reset_time", 64'(time_out), 64'd0);
        check("reset_valid", 64'(valid), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Stop without any start
        #400;
        pulse_stop();
        #50;
        check("nostart_taps", 64'(taps_raw), 64'd0);
        check("nostart_time", 64'(time_out), 64'd0);
        wait_valid("nostart_valid");

        measure("m155", 155, 0);
        measure("m400_sat", 400, 0);

        // Coincident start and stop
        #400;
        start = 1'b1;
        stop  = 1'b1;
        #1;
        start = 1'b0;
        stop  = 1'b0;
        #50;
        check("same_taps", 64'(taps_raw), 64'd0);
        check("same_time", 64'(time_out), 64'd0);
        wait_valid("same_valid");
        #400;
        pulse_stop();
        #50;
        check("same_nolaunch_taps", 64'(taps_raw), 64'd0);

        // Re-arm: old result held while the new measurement runs
        measure("rearm_first", 155, 0);
        #400;
        pulse_start();
        repeat (3) @(posedge clk);
        #1;
        check("rearm_valid_low", 64'(valid), 64'd0);
        check("rearm_hold_time", 64'(time_out), 64'd15);
        check("rearm_hold_taps", 64'(taps_raw), 64'h7fff);
        pulse_stop();
        #50;
        check("rearm_sat_taps", 64'(taps_raw), 64'(ref_taps(N * TD + 1)));
        check("rearm_sat_time", 64'(time_out), 64'd31);
        wait_valid("rearm_valid_high");
        measure("m55", 55, 0);

        // Randomized intervals, some with a redundant second start
        for (int it = 0; it < 24; it++) begin
            d = 10 * $urandom_range(0, 44) + $urandom_range(1, 9);
            s = 0;
            if (d >= 4 && $urandom_range(0, 1) == 1) s = $urandom_range(2, d - 2);
            measure($sformatf("rnd%0d", it), d, s);
        end

        // Reset mid-measurement
        #400;
        pulse_start();
        #100;
        rst = 1'b1;
        #1;
        check("midrst_taps", 64'(taps_raw), 64'd0);
        check("midrst_time", 64'(time_out), 64'd0);
        check("midrst_valid", 64'(valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid_after", 64'(valid), 64'd0);
        #100;
        pulse_stop();
        #50;
        check("midrst_stop_taps", 64'(taps_raw), 64'd0);
        check("midrst_stop_time", 64'(time_out), 64'd0);
        wait_valid("midrst_stop_valid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tdc_top.md
Name: tdc_top

Overview:
- Tapped-delay-line time-to-digital converter. Measures the interval between a rising edge on start and a rising edge on stop, in units of one tap delay.
- Outputs the raw thermometer snapshot of the delay line and its binary tap count.
- Front-end measurement block: the raw snapshot is asynchronous to any clock; clk and rst are used only for control and the valid flag.

Parameters:
- NUM_TAPS, 32, number of delay taps in the line; also the width of taps_raw.
- TAP_DELAY_PS, 10, per-tap propagation delay in ps. Used by the behavioural delay model; a synthesized build replaces it with a carry-chain primitive.

Ports:
- clk  input  1  system clock, control domain only.
- rst  input  1  asynchronous active-high reset.
- start  input  1  measurement start; rising edge launches the line.
- stop  input  1  measurement stop; rising edge freezes the line.
- taps_raw  output  NUM_TAPS  captured thermometer snapshot; bit 0 is the tap nearest the line input.
- time_out  output  $clog2(NUM_TAPS)  number of taps reached at stop, saturated.
- valid  output  1  measurement complete, synchronized to clk.

Behaviour:
- Launch latch:
  - Set by start rising edge; asynchronous, no clock involved.
  - Cleared by rst.
  - Holds high after start returns low, so 1 ps start pulses work.
  - Drives the delay line input.
- Delay line:
  - tap[0] = launch latch delayed by TAP_DELAY_PS.
  - tap[i] = tap[i-1] delayed by TAP_DELAY_PS.
  - A held launch produces a growing thermometer code: 1s from bit 0 upward.
- Capture:
  - On stop rising edge, all taps are sampled into the taps_raw register simultaneously; that register is clocked by stop.
  - The capture also clears the launch latch, so the line drains back to 0.
  - taps_raw holds until the next stop rising edge or rst.
- Encoder:
  - time_out is combinational from taps_raw: the population count of 1s, which tolerates single-bit bubbles.
  - Saturates at NUM_TAPS-1 when the count reaches NUM_TAPS.
  - Must settle within 50 ps of taps_raw changing.
- Valid:
  - Done flag is set asynchronously by stop capture and cleared by the next start rising edge or rst.
  - It is passed through a 2-flop synchronizer on clk to form valid.
  - Latency: valid asserts 2–3 clk cycles after stop.
  - taps_raw and time_out do not depend on clk; they are readable without a running clock.
- Reset (rst=1, asynchronous): launch latch=0, all taps drain to 0, taps_raw=0, time_out=0, done=0, valid=0.
- Boundary cases:
  - stop with no prior start: captures all zeros; time_out=0; valid still asserts.
  - start and stop rising at the same instant: taps_raw=0, time_out=0.
  - Interval ≥ NUM_TAPS*TAP_DELAY_PS: taps_raw all 1s; time_out=NUM_TAPS-1 (saturated).
  - Second start before stop: ignored, since the latch is already set; the measurement is referenced to the first start.
  - New start after a completed measurement: re-arms; the previous taps_raw and time_out are held until the next stop.
  - rst mid-measurement: aborts; all outputs return to reset values; a subsequent stop captures zeros.
- Resolution: time_out = floor(interval / TAP_DELAY_PS). An edge landing exactly on a tap boundary may round either way (±1 tap).

Test Plan:
- Defaults; start 1 ps pulse at 100 ps; stop 1 ps pulse at 250 ps; read at 750 ps -> taps_raw = 0000_0000_0000_0000_0111_1111_1111_1111 (bits 14:0 set); time_out=15.
- start at 100 ps; stop at 500 ps (interval ≥ 320 ps) -> taps_raw all 1s; time_out=31.
- stop pulse with no start -> taps_raw=0; time_out=0; valid asserts within 3 clk cycles.
- start and stop asserted in the same timestep -> taps_raw=0; time_out=0.
- Measure 150 ps; re-arm with a new start; measure 55 ps -> first result 15, held until second stop; then time_out=5 with bits 4:0 set; valid drops on re-arm start and re-asserts after second stop.
- Assert rst between start and stop, then stop -> all outputs 0 during and after reset; valid=0 until a post-reset stop is synchronized.
